neuron_evt_sched: RTL
=====================

# neuron_evt_sched

Event scheduler in front of the neuron core. Shares the core's single event input among `N_SRC` spike/sensor requesters with round-robin arbitration. Also generates the periodic timestep tick and, on each tick, sequences a full leak sweep over every neuron index. Output is a single registered valid/ready slot that drives the core's event port (`ev_valid_i`/`ev_ready_o` side of the core).

## Interface
Parameters:
- `N_SRC`, 4, number of event requesters (2..8)
- `N_NEURON`, 64, neurons in the core; leak sweep length
- `IDX_W`, `$clog2(N_NEURON)`, neuron index width
- `WGT_W`, 8, signed synaptic weight width
- `TICK_DIV`, 1000, clock cycles per timestep (≥ `N_NEURON`+2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `src_valid_i`  in  `N_SRC`  per-source event request
- `src_ready_o`  out  `N_SRC`  per-source accept (one-hot or zero)
- `src_idx_i`  in  `N_SRC*IDX_W`  packed target neuron index, source k at `[k*IDX_W +: IDX_W]`
- `src_wgt_i`  in  `N_SRC*WGT_W`  packed signed weight
- `ev_valid_o`  out  1  event to core valid
- `ev_ready_i`  in  1  core accepts event
- `ev_idx_o`  out  `IDX_W`  neuron index
- `ev_wgt_o`  out  `WGT_W`  weight (0 for leak ops)
- `ev_leak_o`  out  1  1 = leak op, 0 = synaptic event
- `ev_src_o`  out  `$clog2(N_SRC)`  granted source (0 for leak ops)
- `tick_o`  out  1  one-cycle timestep pulse
- `busy_o`  out  1  leak sweep in progress
- `ovr_o`  out  1  sticky: tick arrived while sweep still pending/active
- `drop_o`  out  1  one-cycle pulse: accepted event had index ≥ `N_NEURON`, discarded

## Operation
- Output slot loads when `load_en = !ev_valid_o || ev_ready_i`.
- Tick counter: 0..`TICK_DIV`-1, free-running; at `TICK_DIV`-1 it wraps, pulses `tick_o`, sets `leak_pend`. If `leak_pend` or `busy_o` is already set, `ovr_o` sets as well; only `rst` clears `ovr_o`.
- FSM:
  - `ARB`: if `leak_pend` and `load_en`, go to `LEAK`, clear `leak_pend`, load leak op idx 0. Otherwise grant round-robin among `src_valid_i`. Search starts at `last_grant+1` mod `N_SRC`. Set `src_ready_o[g]=load_en`, load {idx, wgt, src, leak=0}, update `last_grant` on handshake.
  - `LEAK`: `busy_o`=1, all `src_ready_o`=0. On each `load_en`, load the next leak op (idx+1, wgt 0, leak 1). After idx `N_NEURON`-1 is loaded, return to `ARB`.
- Leak has strict priority over requesters; a sweep is never interrupted by events.
- Tick during a sweep: `leak_pend` sets, and a fresh sweep starts immediately after the current one ends. Multiple ticks collapse into one pending sweep.
- Index ≥ `N_NEURON` (non-power-of-two `N_NEURON`): the source is handshaken, nothing is loaded, `drop_o` pulses, and the slot stays free that cycle.
- `src_ready_o` is combinational from `src_valid_i`, `ev_valid_o`, `ev_ready_i` and state. It never depends on its own output.

## Timing
- Reset values:
  - `ev_valid_o`, `src_ready_o`, `tick_o`, `busy_o`, `ovr_o`, `drop_o` = 0
  - `ev_idx_o`, `ev_wgt_o`, `ev_src_o`, `ev_leak_o` = 0
  - tick counter = 0, `last_grant` = `N_SRC`-1 (so source 0 wins first), FSM = `ARB`
- Latency: source handshake at edge n → `ev_valid_o`=1 after edge n.
- Throughput: 1 op/cycle while `ev_ready_i`=1. Payload is held stable while `ev_valid_o && !ev_ready_i`.
- First `tick_o` is in the cycle where the counter reads `TICK_DIV`-1, i.e. `TICK_DIV`-1 cycles after `rst` deasserts.
- Sweep occupies ≥ `N_NEURON` cycles; the first leak op is valid the cycle after the `ARB→LEAK` transition edge.
- `rst` mid-sweep or mid-handshake: everything returns to reset values on the next edge; the pending op is lost.

## Configuration
- `SCHED_STATS_EN` defined: adds `stat_ev_cnt_o` [31:0] (accepted synaptic events) and `stat_sweep_cnt_o` [15:0] (completed sweeps). Both are saturating, cleared by `rst`, and count on core handshake (`ev_valid_o && ev_ready_i`).
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset then idle, `TICK_DIV`=100, `ev_ready_i`=1: `tick_o` pulses at cycles 99, 199. Each tick is followed by 64 leak ops, idx 0..63, `ev_leak_o`=1, `ev_wgt_o`=0; `busy_o` is high throughout.
- All 4 sources valid continuously, `ev_ready_i`=1, no tick: grants follow 0,1,2,3,0,…; `ev_src_o` matches; one event per cycle.
- `ev_ready_i` low 5 cycles with slot full: `ev_valid_o` and payload are held, all `src_ready_o`=0; resume with no loss or duplication.
- Source 2 valid with idx 5, wgt −3, arriving in the same cycle as `tick_o`: the event is forwarded first; the sweep starts on the next free slot, and source 2 is not granted again until the sweep ends.
- `ev_ready_i`=0 across a full `TICK_DIV` period with a sweep active: `ovr_o` sets and stays set; a second sweep runs back-to-back after the first.
- Assert `rst` at leak idx 30: all outputs are 0 next cycle; after release the tick counter restarts and the first grant goes to source 0.

Source files
------------

// File: rtl/neuron_evt_sched.sv
// neuron_evt_sched: round-robin event arbiter with periodic leak sweep; `SCHED_STATS_EN adds stat counters
module neuron_evt_sched #(
  parameter int N_SRC    = 4,
  parameter int N_NEURON = 64,
  parameter int IDX_W    = $clog2(N_NEURON),
  parameter int WGT_W    = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_valid_i,
  output logic [N_SRC-1:0]         src_ready_o,
  input  logic [N_SRC*IDX_W-1:0]   src_idx_i,
  input  logic [N_SRC*WGT_W-1:0]   src_wgt_i,
  output logic                     ev_valid_o,
  input  logic                     ev_ready_i,
  output logic [IDX_W-1:0]         ev_idx_o,
  output logic [WGT_W-1:0]         ev_wgt_o,
  output logic                     ev_leak_o,
  output logic [$clog2(N_SRC)-1:0] ev_src_o,
  output logic                     tick_o,
  output logic                     busy_o,
  output logic                     ovr_o,
  output logic                     drop_o
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]              stat_ev_cnt_o,
  output logic [15:0]              stat_sweep_cnt_o
`endif
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(TICK_DIV);
  typedef enum logic {ARB, LEAK} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic leak_pend, found, load_en, hs, bad, start_leak, last_leak;
  logic [SRC_W-1:0] last_grant, g;
  logic [SRC_W:0] sum;
  logic [IDX_W-1:0] sel_idx;
  logic [WGT_W-1:0] sel_wgt;
  assign load_en = !ev_valid_o || ev_ready_i;
  assign tick_o  = cnt == CNT_W'(TICK_DIV - 1);
  assign busy_o  = state == LEAK || (ev_valid_o && ev_leak_o);
  // round-robin search: nearest valid source after last_grant wins
  always_comb begin
    found = 1'b0;
    g = '0;
    sum = '0;
    for (int k = N_SRC; k > 0; k--) begin
      sum = {1'b0, last_grant} + (SRC_W+1)'(k);
      sum = sum >= (SRC_W+1)'(N_SRC) ? sum - (SRC_W+1)'(N_SRC) : sum;
      if (src_valid_i[sum[SRC_W-1:0]]) begin
        found = 1'b1;
        g = sum[SRC_W-1:0];
      end
    end
  end
  // next state, handshake and leak sequencing; leak outranks requesters
  always_comb begin
    sel_idx     = src_idx_i[g*IDX_W +: IDX_W];
    sel_wgt     = src_wgt_i[g*WGT_W +: WGT_W];
    bad         = {1'b0, sel_idx} >= (IDX_W+1)'(N_NEURON);
    start_leak  = state == ARB && leak_pend && load_en && !rst;
    hs          = state == ARB && !leak_pend && found && load_en && !rst;
    src_ready_o = hs ? (N_SRC'(1) << g) : '0;
    last_leak   = state == LEAK && load_en && ev_idx_o == IDX_W'(N_NEURON - 2);
    state_n     = start_leak ? LEAK : last_leak ? ARB : state;
  end
  // state, tick counter and output slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      cnt        <= '0;
      leak_pend  <= 1'b0;
      ovr_o      <= 1'b0;
      drop_o     <= 1'b0;
      last_grant <= SRC_W'(N_SRC - 1);
      ev_valid_o <= 1'b0;
      ev_idx_o   <= '0;
      ev_wgt_o   <= '0;
      ev_src_o   <= '0;
      ev_leak_o  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= tick_o ? '0 : cnt + 1'b1;
      leak_pend <= tick_o || (leak_pend && !start_leak);
      ovr_o     <= ovr_o || (tick_o && (leak_pend || busy_o));
      drop_o    <= hs && bad;
      if (hs) last_grant <= g;
      if (start_leak || (state == LEAK && load_en)) begin
        ev_valid_o <= 1'b1;
        ev_idx_o   <= start_leak ? '0 : ev_idx_o + 1'b1;
        ev_wgt_o   <= '0;
        ev_src_o   <= '0;
        ev_leak_o  <= 1'b1;
      end else if (hs && !bad) begin
        ev_valid_o <= 1'b1;
        ev_idx_o   <= sel_idx;
        ev_wgt_o   <= sel_wgt;
        ev_src_o   <= g;
        ev_leak_o  <= 1'b0;
      end else if (load_en) begin
        ev_valid_o <= 1'b0;
      end
    end
  end
`ifdef SCHED_STATS_EN
  // saturating counts of delivered synaptic events and completed sweeps
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ev_cnt_o    <= '0;
      stat_sweep_cnt_o <= '0;
    end else if (ev_valid_o && ev_ready_i) begin
      if (!ev_leak_o && stat_ev_cnt_o != '1) stat_ev_cnt_o <= stat_ev_cnt_o + 1'b1;
      if (ev_leak_o && ev_idx_o == IDX_W'(N_NEURON - 1) && stat_sweep_cnt_o != '1)
        stat_sweep_cnt_o <= stat_sweep_cnt_o + 1'b1;
    end
  end
`endif
endmodule
